// File: rtl/trng_harvester.sv
// Harvests words from the ring-oscillator TRNG core into the clk domain, runs
// repetition-count and adaptive-proportion health tests, and queues passing words.
module trng_harvester #(
  parameter int FIFO_DEPTH = 4,
  parameter int RCT_CUTOFF = 3,
  parameter int APT_WINDOW = 16,
  parameter int APT_LO     = 400,
  parameter int APT_HI     = 624
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [63:0] trng_word,
  input  logic        trng_ready,
  output logic [63:0] rnd_data,
  output logic        rnd_valid,
  input  logic        rnd_ready,
  output logic        health_fail,
  output logic        overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(APT_WINDOW) + 1;
  localparam int CW = $clog2(RCT_CUTOFF + 1) + 1;

  logic          s1_reg, s2_reg, s3_reg;
  logic          rise;
  logic [63:0]   cap_word_reg;
  logic          cap_vld_reg;

  logic [63:0]   prev_word_reg;
  logic          prev_vld_reg;
  logic [CW-1:0] rct_cnt_reg, rct_next;
  logic [10:0]   apt_acc_reg, apt_sum;
  logic [NW-1:0] apt_n_reg, apt_n_next;
  logic          win_done, fail_now;
  logic          health_fail_reg, overrun_reg;

  logic [3:0]    byte_pop [8];
  logic [6:0]    popcnt;

  logic [63:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          full, do_pop, wr_req, push, flush;

  // trng_word is stable for several clk cycles around the ready pulse, so only
  // the ready flag needs synchronizing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= trng_ready;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign rise = s2_reg & ~s3_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_word_reg <= '0;
      cap_vld_reg  <= 1'b0;
    end else begin
      cap_vld_reg <= rise & en;
      if (rise) cap_word_reg <= trng_word;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : gen_byte_pop
      assign byte_pop[gi] = 4'($countones(cap_word_reg[gi*8 +: 8]));
    end
  endgenerate

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < 8; i++) popcnt = popcnt + 7'(byte_pop[i]);
  end

  // Health verdict for the word currently in the capture register.
  always_comb begin
    rct_next = CW'(1);
    if (prev_vld_reg && (cap_word_reg == prev_word_reg))
      rct_next = (&rct_cnt_reg) ? rct_cnt_reg : rct_cnt_reg + 1'b1;
    apt_sum    = apt_acc_reg + 11'(popcnt);
    apt_n_next = apt_n_reg + 1'b1;
    win_done   = (apt_n_next == NW'(APT_WINDOW));
    fail_now   = cap_vld_reg &&
                 ((rct_next >= CW'(RCT_CUTOFF)) ||
                  (win_done && ((apt_sum < 11'(APT_LO)) || (apt_sum > 11'(APT_HI)))));
  end

  assign full   = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign do_pop = (count_reg != '0) && rnd_ready;
  assign wr_req = cap_vld_reg && !fail_now && !health_fail_reg;
  assign push   = wr_req && (!full || do_pop);
  assign flush  = !en || fail_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_word_reg   <= '0;
      prev_vld_reg    <= 1'b0;
      rct_cnt_reg     <= '0;
      apt_acc_reg     <= '0;
      apt_n_reg       <= '0;
      health_fail_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else if (!en) begin
      prev_vld_reg    <= 1'b0;
      rct_cnt_reg     <= '0;
      apt_acc_reg     <= '0;
      apt_n_reg       <= '0;
      health_fail_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      if (cap_vld_reg) begin
        rct_cnt_reg   <= rct_next;
        prev_word_reg <= cap_word_reg;
        prev_vld_reg  <= 1'b1;
        apt_acc_reg   <= win_done ? '0 : apt_sum;
        apt_n_reg     <= win_done ? '0 : apt_n_next;
      end
      if (fail_now) health_fail_reg <= 1'b1;
      if (wr_req && full && !do_pop) overrun_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)   wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= cap_word_reg;
  end

  assign rnd_valid   = (count_reg != '0);
  assign rnd_data    = rnd_valid ? mem[rd_ptr_reg] : '0;
  assign health_fail = health_fail_reg;
  assign overrun     = overrun_reg;

endmodule
